// File: rtl/ps2_kbd_serializer_if.sv
// Scancode push interface: valid/ready handshake carrying one byte per transfer.
// The master drives in_valid/in_data; the slave (serializer) answers with in_ready.
interface ps2_kbd_serializer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/ps2_kbd_serializer.sv
// PS/2 device-side keyboard transmitter.
// Scancodes are queued in a small FIFO and sent one at a time as 11-bit PS/2 frames
// {stop, parity, d7..d0, start}, LSB first, with an idle gap between frames.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | lines high, waiting for a queued byte; loads the frame on pop
// HIGH  | ps2_clk high for CLK_DIV clocks; ps2_data shows frame[bit_idx]
// LOW   | ps2_clk low for CLK_DIV clocks; ps2_data held stable
// GAP   | both lines high for GAP_CYCLES clocks before the next frame
module ps2_kbd_serializer #(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    ps2_kbd_serializer_if.slave        in_bus,
    input  logic                       par_inject,
    output logic                       busy,
    output logic [6:0]                 fifo_count,
    output logic                       ps2_clk,
    output logic                       ps2_data
);

    localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    // A zero gap never reaches the GAP state, so its reload value is irrelevant there.
    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic [6:0]  DEPTH_C  = 7'(FIFO_DEPTH);
    localparam bit          NO_GAP   = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [10:0]      frame;
    logic [3:0]       bit_idx;
    logic [3:0]       next_idx;
    logic [15:0]      timer;
    logic [7:0]       head_byte;
    logic             head_parity;
    logic             push;
    logic             pop;

    assign in_bus.in_ready = (fifo_count != DEPTH_C);
    assign push            = in_bus.in_valid && in_bus.in_ready;
    // Popping happens only in IDLE, which is exactly when a new frame gets loaded.
    assign pop             = (state == ST_IDLE) && (fifo_count != 7'd0);
    assign head_byte       = mem[rd_ptr];
    // Odd parity over data+parity; par_inject flips it to force a receiver parity error.
    assign head_parity     = (~^head_byte) ^ par_inject;
    assign next_idx        = bit_idx + 4'd1;

    // FIFO storage: written on accepted pushes; contents need no reset since pointers flush it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_bus.in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 7'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 7'd1;
                2'b01:   fifo_count <= fifo_count - 7'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer: one down-counter times both half-periods and the inter-frame gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            frame    <= '1;
            bit_idx  <= 4'd0;
            timer    <= 16'd0;
            busy     <= 1'b0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        frame    <= {1'b1, head_parity, head_byte, 1'b0};
                        bit_idx  <= 4'd0;
                        ps2_data <= 1'b0;
                        ps2_clk  <= 1'b1;
                        timer    <= DIV_LOAD;
                        busy     <= 1'b1;
                        state    <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (timer == 16'd0) begin
                        ps2_clk <= 1'b0;
                        timer   <= DIV_LOAD;
                        state   <= ST_LOW;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_LOW: begin
                    if (timer == 16'd0) begin
                        ps2_clk <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            ps2_data <= 1'b1;
                            if (NO_GAP) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                timer <= GAP_LOAD;
                                state <= ST_GAP;
                            end
                        end else begin
                            // Data only moves on the rising edge so it is stable at the fall.
                            bit_idx  <= next_idx;
                            ps2_data <= frame[next_idx];
                            timer    <= DIV_LOAD;
                            state    <= ST_HIGH;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_GAP: begin
                    if (timer == 16'd0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                default: begin
                    busy     <= 1'b0;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_serializer.sv
// Self-checking bench for ps2_kbd_serializer: a behavioural PS/2 receiver samples ps2_data on
// every ps2_clk fall and the collected frames are compared against frames built from bytes.
module tb_ps2_kbd_serializer;

    localparam int CLK_DIV      = 4;
    localparam int GAP          = 16;
    localparam int DEPTH        = 8;
    localparam int FRAME_PERIOD = 22 * CLK_DIV + GAP + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       par_inject;
    logic       busy;
    logic [6:0] fifo_count;
    logic       ps2_clk;
    logic       ps2_data;

    ps2_kbd_serializer_if kbd_if ();

    ps2_kbd_serializer #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_bus    (kbd_if),
        .par_inject(par_inject),
        .busy      (busy),
        .fifo_count(fifo_count),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   viol     = 0;
    logic prev_c   = 1'b1;
    logic prev_d   = 1'b1;

    logic       fall_bits[$];
    int         fall_cyc[$];
    logic [7:0] exp_q[$];
    logic       exp_inj[$];
    int         starts[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Receiver front end: one bit per ps2_clk fall, plus a watch on data moving while clk is low.
    always @(negedge clock) begin
        if (prev_c === 1'b1 && ps2_clk === 1'b0) begin
            fall_bits.push_back(ps2_data);
            fall_cyc.push_back(cyc);
        end
        if (ps2_clk === 1'b0 && ps2_data !== prev_d) viol++;
        prev_c = ps2_clk;
        prev_d = ps2_data;
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b, input logic inj);
        logic par;
        par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par ^ inj, b, 1'b0};
    endfunction

    function automatic logic rx_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic push_one(input logic [7:0] b);
        kbd_if.in_valid = 1'b1;
        kbd_if.in_data  = b;
        step();
        kbd_if.in_valid = 1'b0;
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k;
        k = 0;
        while (fall_bits.size() < n && k < budget) begin
            step();
            k++;
        end
        check("wait_falls", 32'(fall_bits.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    endtask

    task automatic pop_frame(output logic [10:0] f, output int c0, output int c10);
        int t;
        f   = '0;
        c0  = 0;
        c10 = 0;
        for (int i = 0; i < 11; i++) begin
            if (fall_bits.size() > 0) begin
                f[i] = fall_bits.pop_front();
                t    = fall_cyc.pop_front();
            end else begin
                f[i] = 1'bx;
                t    = 0;
            end
            if (i == 0)  c0  = t;
            if (i == 10) c10 = t;
        end
    endtask

    task automatic check_frames(input int n);
        logic [10:0] f;
        logic [10:0] ef;
        logic [7:0]  b;
        logic        inj;
        int          c0;
        int          c10;
        wait_falls(11 * n, n * FRAME_PERIOD + 200);
        for (int j = 0; j < n; j++) begin
            pop_frame(f, c0, c10);
            b   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            inj = (exp_inj.size() > 0) ? exp_inj.pop_front() : 1'b0;
            ef  = model_frame(b, inj);
            starts.push_back(c0);
            check($sformatf("frame_bits[%0d] byte %02h", j, b), {21'd0, f}, {21'd0, ef});
            check("frame_span", 32'(c10 - c0), 32'(20 * CLK_DIV));
            check("rx_valid", {31'd0, rx_ok(f)}, {31'd0, ~inj});
            if (!inj) check("rx_byte", {24'd0, f[8:1]}, {24'd0, b});
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [10:0] f;
        int          model_cnt;
        int          n0;
        int          k;

        reset           = 1'b1;
        par_inject      = 1'b0;
        kbd_if.in_valid = 1'b0;
        kbd_if.in_data  = 8'h00;
        repeat (3) step();
        check("rst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {25'd0, fifo_count}, 32'd0);
        check("rst_ready", {31'd0, kbd_if.in_ready}, 32'd1);
        reset = 1'b0;
        step();

        // 0x1C: push latency, exact bit pattern and receiver decode
        push_one(8'h1C);
        exp_q.push_back(8'h1C);
        exp_inj.push_back(1'b0);
        check("t1_count_after_push", {25'd0, fifo_count}, 32'd1);
        check("t1_data_before_load", {31'd0, ps2_data}, 32'd1);
        step();
        check("t1_start_bit", {31'd0, ps2_data}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_count_after_load", {25'd0, fifo_count}, 32'd0);
        f = model_frame(8'h1C, 1'b0);
        check("t1_model_literal", {21'd0, f}, 32'h438);
        check_frames(1);
        wait_idle(GAP + 4 * CLK_DIV + 10);

        // Parity corner bytes followed by a random burst
        push_one(8'h00);
        exp_q.push_back(8'h00);
        exp_inj.push_back(1'b0);
        push_one(8'hFF);
        exp_q.push_back(8'hFF);
        exp_inj.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            push_one(b);
            exp_q.push_back(b);
            exp_inj.push_back(1'b0);
        end
        check_frames(6);
        wait_idle(FRAME_PERIOD);

        // Back-to-back pushes: start-to-start spacing is one full frame period
        starts.delete();
        push_one(8'hF0);
        push_one(8'h1C);
        exp_q.push_back(8'hF0);
        exp_inj.push_back(1'b0);
        exp_q.push_back(8'h1C);
        exp_inj.push_back(1'b0);
        check_frames(2);
        if (starts.size() >= 2) check("t3_period", 32'(starts[1] - starts[0]), 32'(FRAME_PERIOD));
        wait_idle(FRAME_PERIOD);

        // Overfill while a frame is in flight
        b = 8'($urandom_range(0, 255));
        push_one(b);
        exp_q.push_back(b);
        exp_inj.push_back(1'b0);
        repeat (6) step();
        check("t4_busy", {31'd0, busy}, 32'd1);
        model_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            kbd_if.in_valid = 1'b1;
            kbd_if.in_data  = b;
            check("t4_ready", {31'd0, kbd_if.in_ready}, 32'(model_cnt < DEPTH));
            check("t4_count", {25'd0, fifo_count}, 32'(model_cnt));
            if (model_cnt < DEPTH) begin
                exp_q.push_back(b);
                exp_inj.push_back(1'b0);
                model_cnt++;
            end
            step();
        end
        kbd_if.in_valid = 1'b0;
        check("t4_full_count", {25'd0, fifo_count}, 32'(DEPTH));
        check("t4_full_ready", {31'd0, kbd_if.in_ready}, 32'd0);
        check_frames(DEPTH + 1);
        wait_idle(FRAME_PERIOD);

        // Parity injection, with inputs disturbed after the load
        par_inject = 1'b1;
        push_one(8'h1C);
        exp_q.push_back(8'h1C);
        exp_inj.push_back(1'b1);
        step();
        check("t5_loaded", {31'd0, busy}, 32'd1);
        par_inject     = 1'b0;
        kbd_if.in_data = 8'($urandom_range(0, 255));
        check_frames(1);
        wait_idle(FRAME_PERIOD);

        // Reset mid-frame with bytes queued
        for (int i = 0; i < 4; i++) push_one(8'($urandom_range(0, 255)));
        k = 0;
        while (fall_bits.size() < 6 && k < FRAME_PERIOD) begin
            step();
            k++;
        end
        check("t6_reached_bit5", 32'(fall_bits.size()), 32'd6);
        check("t6_queued", {25'd0, fifo_count}, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
        check("t6_count", {25'd0, fifo_count}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ready", {31'd0, kbd_if.in_ready}, 32'd1);
        n0 = fall_bits.size();
        repeat (3 * FRAME_PERIOD) step();
        check("t6_no_more_frames", 32'(fall_bits.size()), 32'(n0));
        check("t6_still_idle", {31'd0, busy}, 32'd0);

        check("data_stable_while_clk_low", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
